// File: rtl/fifo_cmd_rx_pkg.sv
// fifo_cmd_rx_pkg: shared constants and state codes for the ARM->68k FIFO command reader
package fifo_cmd_rx_pkg;
  localparam logic [7:0] FIFO_SYNC_BYTE = 8'h2B;
  typedef enum logic [2:0] {S_HUNT, S_CMD, S_CHK, S_LEN, S_PAY} parse_t;
  typedef enum logic [1:0] {P_IDLE, P_OE, P_GAP} pop_t;
endpackage

// File: rtl/fifo_cmd_rx_pop.sv
// fifo_pop: paced read-strobe generator honouring the FIFO's two-stage edge-sync pop rule
module fifo_pop
  import fifo_cmd_rx_pkg::*;
#(
  parameter int OE_HOLD = 3,
  parameter int GAP = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       want,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_do,
  output logic       fifo_oe,
  output logic       byte_vld,
  output logic       idle,
  output logic [7:0] data
);
  pop_t st;
  logic [7:0] cnt;
  assign idle = st == P_IDLE;
  always_ff @(negedge clk or posedge rst)
    if (rst) begin
      st <= P_IDLE;
      cnt <= '0;
      fifo_oe <= 1'b0;
      byte_vld <= 1'b0;
      data <= '0;
    end else begin
      byte_vld <= 1'b0;
      case (st)
        P_IDLE: if (want && !fifo_empty) begin
          fifo_oe <= 1'b1;
          cnt <= '0;
          st <= P_OE;
        end
        P_OE: if (cnt == 8'(OE_HOLD - 1)) begin
          data <= fifo_do;
          fifo_oe <= 1'b0;
          byte_vld <= 1'b1;
          cnt <= '0;
          st <= P_GAP;
        end else cnt <= cnt + 8'd1;
        P_GAP: if (cnt == 8'(GAP - 1)) st <= P_IDLE;
               else cnt <= cnt + 8'd1;
        default: st <= P_IDLE;
      endcase
    end
endmodule

// File: rtl/fifo_cmd_rx.sv
// fifo_cmd_rx: FIFO consumer that deframes ARM command packets (sync, cmd, ~cmd, len, payload)
module fifo_cmd_rx
  import fifo_cmd_rx_pkg::*;
#(
  parameter int OE_HOLD = 3,
  parameter int GAP = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_do,
  output logic       fifo_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd,
  output logic [7:0] cmd_len,
  output logic       pl_valid,
  output logic [7:0] pl_data,
  output logic       pl_last,
  input  logic       pl_ready,
  output logic       busy,
  output logic       err_sync,
  output logic       err_chk,
  output logic       err_tout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  parse_t st;
  logic [7:0] cmd_q, remain, data;
  logic [TW-1:0] tcnt;
  logic byte_vld, pop_idle;
  fifo_pop #(.OE_HOLD(OE_HOLD), .GAP(GAP)) u_pop (
    .clk(clk),
    .rst(rst),
    .want(!pl_valid || pl_ready),
    .fifo_empty(fifo_empty),
    .fifo_do(fifo_do),
    .fifo_oe(fifo_oe),
    .byte_vld(byte_vld),
    .idle(pop_idle),
    .data(data)
  );
  always_ff @(negedge clk or posedge rst)
    if (rst) begin
      st <= S_HUNT;
      cmd_q <= '0;
      remain <= '0;
      tcnt <= '0;
      cmd_valid <= 1'b0;
      cmd <= '0;
      cmd_len <= '0;
      pl_valid <= 1'b0;
      pl_data <= '0;
      pl_last <= 1'b0;
      busy <= 1'b0;
      err_sync <= 1'b0;
      err_chk <= 1'b0;
      err_tout <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      err_sync <= 1'b0;
      err_chk <= 1'b0;
      err_tout <= 1'b0;
      // a byte left over from an aborted packet still completes its handshake
      if (pl_valid && pl_ready) begin
        pl_valid <= 1'b0;
        pl_last <= 1'b0;
        if (st == S_PAY) begin
          remain <= remain - 8'd1;
          if (remain == 8'd1) begin
            st <= S_HUNT;
            busy <= 1'b0;
          end
        end
      end
      if (byte_vld)
        case (st)
          S_HUNT: if (data == FIFO_SYNC_BYTE) begin
            st <= S_CMD;
            busy <= 1'b1;
          end else err_sync <= 1'b1;
          S_CMD: begin
            cmd_q <= data;
            st <= S_CHK;
          end
          S_CHK: if (data == ~cmd_q) st <= S_LEN;
                 else begin
                   err_chk <= 1'b1;
                   busy <= 1'b0;
                   st <= S_HUNT;
                 end
          S_LEN: begin
            cmd <= cmd_q;
            cmd_len <= data;
            cmd_valid <= 1'b1;
            remain <= data;
            st <= data == 8'd0 ? S_HUNT : S_PAY;
            busy <= data != 8'd0;
          end
          S_PAY: begin
            pl_valid <= 1'b1;
            pl_data <= data;
            pl_last <= remain == 8'd1;
          end
          default: st <= S_HUNT;
        endcase
      if (byte_vld || !busy) tcnt <= '0;
      else if (pop_idle && fifo_empty) begin
        if (tcnt == TW'(TIMEOUT - 1)) begin
          tcnt <= '0;
          err_tout <= 1'b1;
          busy <= 1'b0;
          st <= S_HUNT;
        end else tcnt <= tcnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_fifo_cmd_rx.sv
// tb_fifo_cmd_rx: directed table, corner sequences and randomized streams vs a packet-level model
module tb_fifo_cmd_rx;
  localparam int TO = 100;
  typedef logic [7:0] bq_t[$];
  typedef logic [31:0] eq_t[$];
  typedef struct {
    logic [7:0] b[10];
    int n, ncmd, npl, nsync, nchk;
    logic [7:0] lcmd, llen;
  } vec_t;

  logic clk = 0, rst = 1, fifo_empty = 1, pl_ready = 0;
  logic [7:0] fifo_do = 0;
  logic fifo_oe, cmd_valid, pl_valid, pl_last, busy, err_sync, err_chk, err_tout;
  logic [7:0] cmd, cmd_len, pl_data;
  logic [31:0] outs;
  assign outs = {fifo_oe, cmd_valid, cmd, cmd_len, pl_valid, pl_data, pl_last, busy,
                 err_sync, err_chk, err_tout};

  fifo_cmd_rx #(.OE_HOLD(3), .GAP(3), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_do(fifo_do), .fifo_oe(fifo_oe),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_len(cmd_len), .pl_valid(pl_valid),
    .pl_data(pl_data), .pl_last(pl_last), .pl_ready(pl_ready), .busy(busy),
    .err_sync(err_sync), .err_chk(err_chk), .err_tout(err_tout)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0, ready_mode = 0;
  int last_rise = -100, last_fall = 0, tout_cyc = -1, rises = 0;
  logic prev_oe = 0;
  bq_t q;
  eq_t got;

  function automatic logic [31:0] ev(input int t, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] tt;
    tt = 8'(t);
    return {tt, a, b, 8'h00};
  endfunction

  // packet-level reference: walks the byte stream by index and lists the events it must produce
  function automatic eq_t model(input bq_t s);
    eq_t e;
    int i, n, len;
    e = {};
    i = 0;
    n = s.size();
    while (i < n) begin
      if (s[i] != 8'h2B) begin
        e.push_back(ev(3, 0, 0));
        i++;
      end else if (i + 2 >= n) begin
        e.push_back(ev(5, 0, 0));
        i = n;
      end else if (s[i+2] != ~s[i+1]) begin
        e.push_back(ev(4, 0, 0));
        i += 3;
      end else if (i + 3 >= n) begin
        e.push_back(ev(5, 0, 0));
        i = n;
      end else begin
        len = int'(s[i+3]);
        e.push_back(ev(1, s[i+1], s[i+3]));
        for (int k = 0; k < len; k++) begin
          if (i + 4 + k >= n) begin
            e.push_back(ev(5, 0, 0));
            break;
          end
          e.push_back(ev(2, s[i+4+k], {7'b0, k == len - 1}));
        end
        i = (i + 4 + len > n) ? n : i + 4 + len;
      end
    end
    return e;
  endfunction

  function automatic int cnt_ev(input eq_t e, input int t);
    int c;
    c = 0;
    for (int i = 0; i < e.size(); i++) if (e[i][31:24] == t[7:0]) c++;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] x);
    checks++;
    if (g !== x) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, g, x);
    end
  endtask

  task automatic sync_fifo();
    fifo_empty = q.size() == 0;
    fifo_do = q.size() != 0 ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    sync_fifo();
  endtask

  task automatic push_all(input bq_t s);
    for (int i = 0; i < s.size(); i++) push(s[i]);
  endtask

  task automatic cmp_events(input string name, input eq_t x);
    check({name, "_count"}, got.size(), x.size());
    for (int i = 0; i < x.size() && i < got.size(); i++) check(name, got[i], x[i]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 5000 && !(q.size() == 0 && !fifo_oe && !busy && !pl_valid)) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, n < 5000, 1);
    repeat (12) @(posedge clk);
    #1;
  endtask

  // FIFO model: pops on the falling edge of the read strobe
  always @(negedge fifo_oe) if (q.size() != 0) begin
    void'(q.pop_front());
    sync_fifo();
  end

  always @(posedge clk) begin
    cyc++;
    pl_ready = ready_mode == 1 ? 1'($urandom_range(0, 1)) : ready_mode == 0;
    if (pl_valid && pl_ready) got.push_back(ev(2, pl_data, {7'b0, pl_last}));
    if (cmd_valid) got.push_back(ev(1, cmd, cmd_len));
    if (err_sync) got.push_back(ev(3, 0, 0));
    if (err_chk) got.push_back(ev(4, 0, 0));
    if (err_tout) begin
      got.push_back(ev(5, 0, 0));
      tout_cyc = cyc;
    end
    if (fifo_oe && !prev_oe) begin
      rises++;
      if (last_rise != -100) check("pop_period_ge7", cyc - last_rise >= 7, 1);
      last_rise = cyc;
    end
    if (!fifo_oe && prev_oe) last_fall = cyc;
    if (fifo_oe) check("oe_while_nonempty", fifo_empty, 0);
    if (rst) last_rise = -100;
    prev_oe = fifo_oe;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[3];
    bq_t s;
    eq_t x;
    int n, r0;
    tv[0].b = '{8'h2B, 8'h11, 8'hEE, 8'h02, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[0].n = 6; tv[0].ncmd = 1; tv[0].npl = 2; tv[0].nsync = 0; tv[0].nchk = 0;
    tv[0].lcmd = 8'h11; tv[0].llen = 8'h02;
    tv[1].b = '{8'h00, 8'h2B, 8'h22, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[1].n = 5; tv[1].ncmd = 1; tv[1].npl = 0; tv[1].nsync = 1; tv[1].nchk = 0;
    tv[1].lcmd = 8'h22; tv[1].llen = 8'h00;
    tv[2].b = '{8'h2B, 8'h33, 8'h33, 8'h2B, 8'h44, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00};
    tv[2].n = 7; tv[2].ncmd = 1; tv[2].npl = 0; tv[2].nsync = 0; tv[2].nchk = 1;
    tv[2].lcmd = 8'h44; tv[2].llen = 8'h00;

    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs, 32'h0);
    rst = 0;
    ready_mode = 0;

    for (int v = 0; v < 3; v++) begin
      got = {};
      s = {};
      for (int j = 0; j < tv[v].n; j++) s.push_back(tv[v].b[j]);
      push_all(s);
      drain("vec");
      check("vec_ncmd", cnt_ev(got, 1), tv[v].ncmd);
      check("vec_npl", cnt_ev(got, 2), tv[v].npl);
      check("vec_nsync", cnt_ev(got, 3), tv[v].nsync);
      check("vec_nchk", cnt_ev(got, 4), tv[v].nchk);
      check("vec_cmd_held", {cmd, cmd_len}, {tv[v].lcmd, tv[v].llen});
      check("vec_fifo_empty", q.size(), 0);
      check("vec_busy_low", busy, 0);
      cmp_events("vec_events", model(s));
    end

    got = {};
    tout_cyc = -1;
    s = '{8'h2B, 8'h55, 8'hAA, 8'h03, 8'h01};
    push_all(s);
    x = model(s);
    n = 0;
    while (n < 3000 && tout_cyc < 0) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("tout_seen", tout_cyc >= 0, 1);
    check("tout_delay_window", (tout_cyc - last_fall >= TO) && (tout_cyc - last_fall <= TO + 6), 1);
    check("tout_busy_low", busy, 0);
    s = '{8'h2B, 8'h66, 8'h99, 8'h00};
    push_all(s);
    drain("tout_next");
    x = {x, model(s)};
    cmp_events("tout_events", x);

    got = {};
    ready_mode = 2;
    s = '{8'h2B, 8'h77, 8'h88, 8'h04, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    push_all(s);
    n = 0;
    while (n < 500 && !pl_valid) begin
      @(posedge clk);
      n++;
    end
    check("stall_pl_seen", pl_valid, 1);
    r0 = rises;
    repeat (50) @(posedge clk);
    #1;
    check("stall_no_oe", rises - r0, 0);
    check("stall_hold", {pl_valid, pl_data, pl_last}, {1'b1, 8'hD1, 1'b0});
    ready_mode = 0;
    drain("stall");
    cmp_events("stall_events", model(s));

    got = {};
    s = '{8'h2B, 8'hC1, 8'h3E, 8'h00, 8'h2B, 8'hC2, 8'h3D, 8'h00};
    r0 = rises;
    push_all(s);
    n = 0;
    while (n < 200 && rises - r0 < 2) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_pop_reached", rises - r0, 2);
    #1;
    rst = 1;
    #1;
    check("rst_async_outputs", outs, 32'h0);
    check("rst_byte_consumed", q.size(), 6);
    s = q;
    @(posedge clk);
    #1;
    rst = 0;
    got = {};
    drain("rst_resume");
    cmp_events("rst_events", model(s));

    for (int t = 0; t < 6; t++) begin
      logic [7:0] c, g, l;
      int k;
      got = {};
      s = {};
      ready_mode = t % 2 == 0 ? 1 : 0;
      for (int p = 0; p < 10; p++) begin
        k = $urandom_range(0, 5);
        c = 8'($urandom_range(0, 255));
        if (k == 0) begin
          g = c == 8'h2B ? 8'h2C : c;
          s.push_back(g);
        end else if (k == 1) begin
          g = 8'($urandom_range(1, 255));
          s.push_back(8'h2B);
          s.push_back(c);
          s.push_back(~c ^ g);
        end else begin
          l = 8'($urandom_range(0, 5));
          s.push_back(8'h2B);
          s.push_back(c);
          s.push_back(~c);
          s.push_back(l);
          for (int j = 0; j < int'(l); j++) s.push_back(8'($urandom_range(0, 255)));
        end
      end
      push_all(s);
      drain("rand");
      cmp_events("rand_events", model(s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
